line_follow_fsm: RTL and testbench

- Parametrised successor to the 3-sensor line follower. Takes N filtered line sensors, computes a signed position error, and drives registered per-wheel duty codes and directions for the existing PWM blocks.
- Adds what the 3-sensor version lacks: a control FSM with enable, lost-line timeout, a directed search spin, search-timeout halt, and last-side memory.
- Sits between the sensor filters and two PWM instances at top level.

---
 rtl/line_follow_fsm.sv | 255 +++++++++++++++++++++++++
 tb/tb_line_follow_fsm.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/line_follow_fsm.sv
// Line follower control FSM: N-sensor position error to registered wheel duty/direction.
// Optional duty ramping is enabled by defining LINE_FOLLOW_RAMP_EN.
module line_follow_fsm #(
    parameter int NUM_SENSORS    = 5,
    parameter int SPEED_W        = 8,
    parameter int MAX_SPEED      = 128,
    parameter int HALF_SPEED     = 64,
    parameter int STEP           = 32,
    parameter int LOST_TIMEOUT   = 4,
    parameter int SEARCH_TIMEOUT = 16
`ifdef LINE_FOLLOW_RAMP_EN
    ,
    parameter int RAMP_STEP      = 8
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic [NUM_SENSORS-1:0] sensors_i,
    output logic [SPEED_W-1:0]     speed_l_o,
    output logic [SPEED_W-1:0]     speed_r_o,
    output logic                   dir_l_o,
    output logic                   dir_r_o,
    output logic [2:0]             state_o,
    output logic                   line_lost_o,
    output logic                   halted_o
);

    localparam int IW  = $clog2(NUM_SENSORS);
    localparam int EW  = $clog2(2 * NUM_SENSORS) + 1;
    localparam int PW  = EW + SPEED_W;
    localparam int LCW = $clog2(LOST_TIMEOUT + 1);
    localparam int SCW = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [SPEED_W-1:0] MAX_C  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] HALF_C = SPEED_W'(HALF_SPEED);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FOLLOW = 3'd1,
        LOST   = 3'd2,
        SEARCH = 3'd3,
        HALT   = 3'd4
    } state_t;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } side_t;

    state_t             state_q, state_d;
    side_t              lastSide_q, lastSide_d;
    logic [LCW-1:0]     lostCnt_q, lostCnt_d;
    logic [SCW-1:0]     searchCnt_q, searchCnt_d;
    logic [SPEED_W-1:0] speedL_q, speedL_d, speedR_q, speedR_d;
    logic               dirL_q, dirL_d, dirR_q, dirR_d;
    logic               lineLost_q, halted_q;

    logic [IW-1:0]        lo, hi;
    logic                 anyActive;
    logic signed [EW-1:0] err;
    logic [EW-1:0]        absErr;
    logic [PW-1:0]        prod;
    logic [SPEED_W-1:0]   corr, inner, corrL, corrR;
    logic [SPEED_W-1:0]   tgtL, tgtR;
    logic                 tgtDirL, tgtDirR, applyCorr, spin;

    // Line position from the outermost active sensors; a wide line still centres correctly.
    always_comb begin
        lo = '0;
        hi = '0;
        anyActive = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (!sensors_i[i]) begin
                if (!anyActive) lo = IW'(i);
                hi = IW'(i);
                anyActive = 1'b1;
            end
        end
        err    = $signed(EW'(lo) + EW'(hi) - EW'(NUM_SENSORS - 1));
        absErr = err[EW-1] ? (~err + 1'b1) : err;
        prod   = PW'(absErr) * PW'(STEP);
        corr   = (prod >= PW'(MAX_SPEED)) ? MAX_C : prod[SPEED_W-1:0];
        inner  = MAX_C - corr;
        corrL  = (!err[EW-1] && err != '0) ? inner : MAX_C;
        corrR  = err[EW-1] ? inner : MAX_C;
    end

    always_comb begin
        state_d     = state_q;
        lastSide_d  = lastSide_q;
        lostCnt_d   = lostCnt_q;
        searchCnt_d = searchCnt_q;
        tgtL        = speedL_q;
        tgtR        = speedR_q;
        tgtDirL     = dirL_q;
        tgtDirR     = dirR_q;
        applyCorr   = 1'b0;
        spin        = 1'b0;
        if (!enable_i) begin
            state_d     = IDLE;
            lostCnt_d   = '0;
            searchCnt_d = '0;
            tgtL        = '0;
            tgtR        = '0;
            tgtDirL     = 1'b1;
            tgtDirR     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FOLLOW;
                    tgtL    = '0;
                    tgtR    = '0;
                    tgtDirL = 1'b1;
                    tgtDirR = 1'b1;
                end
                FOLLOW: begin
                    if (anyActive) begin
                        applyCorr = 1'b1;
                    end else begin
                        state_d   = LOST;
                        lostCnt_d = LCW'(1);
                    end
                end
                LOST: begin
                    // Reacquire is checked first so it beats a simultaneous timeout.
                    if (anyActive) begin
                        state_d   = FOLLOW;
                        lostCnt_d = '0;
                        applyCorr = 1'b1;
                    end else if (lostCnt_q == LCW'(LOST_TIMEOUT)) begin
                        state_d     = SEARCH;
                        lostCnt_d   = '0;
                        searchCnt_d = '0;
                        spin        = 1'b1;
                    end else begin
                        lostCnt_d = lostCnt_q + 1'b1;
                    end
                end
                SEARCH: begin
                    if (anyActive) begin
                        state_d     = FOLLOW;
                        searchCnt_d = '0;
                        applyCorr   = 1'b1;
                    end else begin
                        searchCnt_d = (searchCnt_q == SCW'(SEARCH_TIMEOUT)) ?
                                      searchCnt_q : searchCnt_q + 1'b1;
                        if (searchCnt_d == SCW'(SEARCH_TIMEOUT)) begin
                            state_d = HALT;
                            tgtL    = '0;
                            tgtR    = '0;
                            tgtDirL = 1'b1;
                            tgtDirR = 1'b1;
                        end else begin
                            spin = 1'b1;
                        end
                    end
                end
                HALT: begin
                    tgtL    = '0;
                    tgtR    = '0;
                    tgtDirL = 1'b1;
                    tgtDirR = 1'b1;
                end
                default: state_d = IDLE;
            endcase
            if (applyCorr) begin
                tgtL    = corrL;
                tgtR    = corrR;
                tgtDirL = 1'b1;
                tgtDirR = 1'b1;
                if (err != '0) lastSide_d = err[EW-1] ? RIGHT : LEFT;
            end
            if (spin) begin
                tgtL    = HALF_C;
                tgtR    = HALF_C;
                tgtDirL = (lastSide_q == RIGHT);
                tgtDirR = (lastSide_q == LEFT);
            end
        end
    end

`ifdef LINE_FOLLOW_RAMP_EN
    localparam logic [SPEED_W-1:0] RAMP_C = SPEED_W'(RAMP_STEP);

    function automatic logic [SPEED_W-1:0] rampTo(input logic [SPEED_W-1:0] cur,
                                                   input logic [SPEED_W-1:0] tgt);
        if (tgt > cur) return ((tgt - cur) > RAMP_C) ? cur + RAMP_C : tgt;
        else           return ((cur - tgt) > RAMP_C) ? cur - RAMP_C : tgt;
    endfunction

    // A wheel only flips direction once it has ramped down to standstill.
    always_comb begin
        speedL_d = rampTo(speedL_q, tgtL);
        speedR_d = rampTo(speedR_q, tgtR);
        dirL_d   = dirL_q;
        dirR_d   = dirR_q;
        if (tgtDirL != dirL_q) begin
            speedL_d = rampTo(speedL_q, '0);
            if (speedL_q == '0) dirL_d = tgtDirL;
        end
        if (tgtDirR != dirR_q) begin
            speedR_d = rampTo(speedR_q, '0);
            if (speedR_q == '0) dirR_d = tgtDirR;
        end
        if (!enable_i) begin
            speedL_d = '0;
            speedR_d = '0;
            dirL_d   = 1'b1;
            dirR_d   = 1'b1;
        end
    end
`else
    always_comb begin
        speedL_d = tgtL;
        speedR_d = tgtR;
        dirL_d   = tgtDirL;
        dirR_d   = tgtDirR;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lastSide_q  <= RIGHT;
            lostCnt_q   <= '0;
            searchCnt_q <= '0;
            speedL_q    <= '0;
            speedR_q    <= '0;
            dirL_q      <= 1'b1;
            dirR_q      <= 1'b1;
            lineLost_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastSide_q  <= lastSide_d;
            lostCnt_q   <= lostCnt_d;
            searchCnt_q <= searchCnt_d;
            speedL_q    <= speedL_d;
            speedR_q    <= speedR_d;
            dirL_q      <= dirL_d;
            dirR_q      <= dirR_d;
            lineLost_q  <= (state_d == LOST) || (state_d == SEARCH);
            halted_q    <= (state_d == HALT);
        end
    end

    assign speed_l_o   = speedL_q;
    assign speed_r_o   = speedR_q;
    assign dir_l_o     = dirL_q;
    assign dir_r_o     = dirR_q;
    assign state_o     = state_q;
    assign line_lost_o = lineLost_q;
    assign halted_o    = halted_q;

endmodule

// File: tb/tb_line_follow_fsm.sv
// Directed self-checking bench for line_follow_fsm in its default (no ramp) build.
module tb_line_follow_fsm;

    logic       clk;
    logic       rstN;
    logic       enable;
    logic [4:0] sensors;
    logic [7:0] speedL, speedR;
    logic       dirL, dirR;
    logic [2:0] state;
    logic       lineLost, halted;

    int compareCount  = 0;
    int mismatchCount = 0;

    line_follow_fsm dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .enable_i    (enable),
        .sensors_i   (sensors),
        .speed_l_o   (speedL),
        .speed_r_o   (speedR),
        .dir_l_o     (dirL),
        .dir_r_o     (dirR),
        .state_o     (state),
        .line_lost_o (lineLost),
        .halted_o    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one input vector, then step just past the next rising edge.
    task automatic applyStimulus(input logic en, input logic [4:0] sens);
        enable  = en;
        sensors = sens;
        @(posedge clk);
        #1;
    endtask

    task automatic checkDrive(input string tag, input int expState, input int expL,
                              input int expR, input int expDirL, input int expDirR);
        checkOutput({tag, ".state"}, state, expState);
        checkOutput({tag, ".speedL"}, speedL, expL);
        checkOutput({tag, ".speedR"}, speedR, expR);
        checkOutput({tag, ".dirL"}, dirL, expDirL);
        checkOutput({tag, ".dirR"}, dirR, expDirR);
    endtask

    initial begin
        rstN    = 1'b0;
        enable  = 1'b0;
        sensors = 5'b11111;
        repeat (2) @(posedge clk);
        #1;
        checkDrive("reset", 0, 0, 0, 1, 1);
        checkOutput("reset.lineLost", lineLost, 0);
        checkOutput("reset.halted", halted, 0);
        rstN = 1'b1;

        applyStimulus(1'b1, 5'b11011);
        checkDrive("start", 1, 0, 0, 1, 1);
        applyStimulus(1'b1, 5'b11011);
        checkDrive("centre", 1, 128, 128, 1, 1);
        applyStimulus(1'b1, 5'b11110);
        checkDrive("errM4", 1, 128, 0, 1, 1);
        applyStimulus(1'b1, 5'b11001);
        checkDrive("errM1", 1, 128, 96, 1, 1);
        applyStimulus(1'b1, 5'b01111);
        checkDrive("errP4", 1, 0, 128, 1, 1);
        applyStimulus(1'b1, 5'b10111);
        checkDrive("errP2", 1, 64, 128, 1, 1);
        applyStimulus(1'b1, 5'b11001);
        checkDrive("errM1b", 1, 128, 96, 1, 1);
        applyStimulus(1'b1, 5'b00000);
        checkDrive("allOn", 1, 128, 128, 1, 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'b11111);
            checkDrive($sformatf("lost%0d", i), 2, 128, 128, 1, 1);
            checkOutput($sformatf("lost%0d.lineLost", i), lineLost, 1);
        end
        applyStimulus(1'b1, 5'b11111);
        checkDrive("searchR", 3, 64, 64, 1, 0);
        checkOutput("searchR.lineLost", lineLost, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'b11111);
            checkOutput($sformatf("searchR%0d.state", i), state, 3);
        end
        applyStimulus(1'b1, 5'b11011);
        checkDrive("reacquire", 1, 128, 128, 1, 1);
        checkOutput("reacquire.lineLost", lineLost, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'b11111);
            checkOutput($sformatf("haltLost%0d.state", i), state, 2);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 5'b11111);
            checkOutput($sformatf("haltSearch%0d.state", i), state, 3);
        end
        applyStimulus(1'b1, 5'b11111);
        checkDrive("halt", 4, 0, 0, 1, 1);
        checkOutput("halt.halted", halted, 1);
        checkOutput("halt.lineLost", lineLost, 0);
        applyStimulus(1'b1, 5'b11011);
        checkOutput("haltHold.state", state, 4);
        applyStimulus(1'b0, 5'b11011);
        checkDrive("haltExit", 0, 0, 0, 1, 1);
        checkOutput("haltExit.halted", halted, 0);
        applyStimulus(1'b1, 5'b11011);
        checkOutput("restart.state", state, 1);
        applyStimulus(1'b1, 5'b11011);
        checkDrive("restartRun", 1, 128, 128, 1, 1);

        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'b11111);
        checkOutput("tieLost.state", state, 2);
        applyStimulus(1'b1, 5'b11110);
        checkDrive("tieReacquire", 1, 128, 0, 1, 1);

        applyStimulus(1'b1, 5'b01111);
        checkDrive("goLeft", 1, 0, 128, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'b11111);
        checkDrive("leftLostHold", 2, 0, 128, 1, 1);
        applyStimulus(1'b1, 5'b11111);
        checkDrive("searchL", 3, 64, 64, 0, 1);
        applyStimulus(1'b0, 5'b11111);
        checkDrive("disableSearch", 0, 0, 0, 1, 1);
        checkOutput("disableSearch.lineLost", lineLost, 0);

        applyStimulus(1'b1, 5'b11001);
        applyStimulus(1'b1, 5'b11001);
        checkDrive("preReset", 1, 128, 96, 1, 1);
        #3;
        rstN = 1'b0;
        #1;
        checkDrive("asyncReset", 0, 0, 0, 1, 1);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(1'b1, 5'b11011);
        checkOutput("postReset.state", state, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
